// File: rtl/dynamic_preadd_mult_pkg.sv
// Shared types for the dynamic pre-adder multiplier.
// The pre-adder operation travels down the pipeline as a typed value.
package dynamic_preadd_mult_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } preadd_op_e;

endpackage

// File: rtl/dynamic_preadd_mult_preadd_stage.sv
// Registered signed pre-adder: ad = d +/- a, computed one bit wider than the operands
// so that the result is exact over the whole input range.
module preadd_stage
    import dynamic_preadd_mult_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  preadd_op_e          op,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] d,
    output logic signed [W:0]   ad
);

    logic signed [W:0] a_ext;
    logic signed [W:0] d_ext;

    assign a_ext = {a[W-1], a};
    assign d_ext = {d[W-1], d};

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; the async clear keeps the pipeline free of stale samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ad <= '0;
        end else if (ce) begin
            ad <= (op == OP_SUB) ? d_ext - a_ext : d_ext + a_ext;
        end
    end

endmodule

// File: rtl/dynamic_preadd_mult.sv
// Three-stage pipelined signed pre-adder multiplier: pout = (din +/- ain) * bin.
// Register layout follows the DSP slice (A/D/B input, AD pre-add, M/P output).
module dynamic_preadd_mult
    import dynamic_preadd_mult_pkg::*;
#(
    parameter int AW = 16,
    parameter int BW = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    subadd,
    input  logic signed [AW-1:0]    ain,
    input  logic signed [AW-1:0]    din,
    input  logic signed [BW-1:0]    bin,
    output logic signed [AW+BW:0]   pout
);

    localparam int MW = AW + 1 + BW;

    logic signed [AW-1:0] a_r;
    logic signed [AW-1:0] d_r;
    logic signed [BW-1:0] b_r;
    logic signed [BW-1:0] b_r2;
    preadd_op_e           op_r;
    logic signed [AW:0]   ad_r;
    logic signed [MW-1:0] ad_ext;
    logic signed [MW-1:0] b_ext;

    // S1: operand registers, subadd captured with its operands
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r  <= '0;
            d_r  <= '0;
            b_r  <= '0;
            op_r <= OP_ADD;
        end else if (ce) begin
            a_r  <= ain;
            d_r  <= din;
            b_r  <= bin;
            op_r <= preadd_op_e'(subadd);
        end
    end

    // S2: pre-adder, with B delayed so it stays aligned with its sample
    preadd_stage #(
        .W (AW)
    ) u_preadd (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .op  (op_r),
        .a   (a_r),
        .d   (d_r),
        .ad  (ad_r)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_r2 <= '0;
        end else if (ce) begin
            b_r2 <= b_r;
        end
    end

    // S3: full-precision product; operands widened explicitly so no bits are lost
    assign ad_ext = {{BW{ad_r[AW]}}, ad_r};
    assign b_ext  = {{(AW + 1){b_r2[BW-1]}}, b_r2};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pout <= '0;
        end else if (ce) begin
            pout <= ad_ext * b_ext;
        end
    end

endmodule

// File: tb/tb_dynamic_preadd_mult.sv
// Self-checking bench for dynamic_preadd_mult against a plain-arithmetic reference model
// that treats the pipeline as a 3-deep queue of enabled samples.
module tb_dynamic_preadd_mult;

    localparam int AW = 16;
    localparam int BW = 16;
    localparam int MW = AW + 1 + BW;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  ce;
    logic                  subadd;
    logic signed [AW-1:0]  ain;
    logic signed [AW-1:0]  din;
    logic signed [BW-1:0]  bin;
    logic signed [MW-1:0]  pout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dynamic_preadd_mult #(
        .AW (AW),
        .BW (BW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .subadd (subadd),
        .ain    (ain),
        .din    (din),
        .bin    (bin),
        .pout   (pout)
    );

    function automatic logic signed [63:0] model(input int d, input int a, input int b, input bit s);
        longint pre;
        pre = s ? (longint'(d) - longint'(a)) : (longint'(d) + longint'(a));
        return pre * longint'(b);
    endfunction

    function automatic int rnd(input int lo, input int hi);
        return lo + int'($urandom_range(hi - lo));
    endfunction

    task automatic drive(input int d, input int a, input int b, input bit s);
        din    = AW'(d);
        ain    = AW'(a);
        bin    = BW'(b);
        subadd = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic signed [63:0] obs;
        rst = 1'b1;
        ce  = 1'b1;
        drive(100, 20, 3, 1'b0);
        repeat (4) tick();
        #2;
        rst = 1'b0;
        #1;
        obs = pout;
        total++;
        if (obs !== 64'sd0) begin
            bad++;
            $display("FAIL reset_immediate: got %0d expected 0", obs);
        end
        for (int i = 0; i < 4; i++) begin
            ce = (i != 2);
            drive(1000 + i, -7, 9, i[0]);
            tick();
            obs = pout;
            total++;
            if (obs !== 64'sd0) begin
                bad++;
                $display("FAIL reset_held[%0d]: got %0d expected 0", i, obs);
            end
        end
        ce  = 1'b1;
        rst = 1'b1;
    endtask

    // Directed single samples between zero flushes: checks exact latency and value.
    task automatic test_directed();
        int d_t[4] = '{5, -7, -32768, 32767};
        int a_t[4] = '{3, 2, -32768, -32768};
        int b_t[4] = '{-4, 6, -32768, 32767};
        bit s_t[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic signed [63:0] obs;
        logic signed [63:0] exp;
        ce = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 1'b0);
            repeat (3) tick();
            drive(d_t[k], a_t[k], b_t[k], s_t[k]);
            exp = model(d_t[k], a_t[k], b_t[k], s_t[k]);
            tick();
            drive(0, 0, 0, 1'b0);
            tick();
            obs = pout;
            total++;
            if (obs !== 64'sd0) begin
                bad++;
                $display("FAIL directed_early[%0d]: got %0d expected 0", k, obs);
            end
            tick();
            obs = pout;
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL directed[%0d]: got %0d expected %0d", k, obs, exp);
            end
            tick();
            obs = pout;
            total++;
            if (obs !== 64'sd0) begin
                bad++;
                $display("FAIL directed_late[%0d]: got %0d expected 0", k, obs);
            end
        end
    endtask

    // 4 add then 4 subtract samples in [-10,10], back to back, plus a zero flush.
    task automatic test_stream();
        logic signed [63:0] q[$];
        logic signed [63:0] obs;
        logic signed [63:0] exp;
        int d, a, b;
        bit s;
        ce = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                d = rnd(-10, 10);
                a = rnd(-10, 10);
                b = rnd(-10, 10);
                s = (i >= 4);
            end else begin
                d = 0; a = 0; b = 0; s = 1'b0;
            end
            drive(d, a, b, s);
            q.push_back(model(d, a, b, s));
            tick();
            if (q.size() == 3) begin
                exp = q.pop_front();
                obs = pout;
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL stream[%0d]: got %0d expected %0d", i - 2, obs, exp);
                end
            end
        end
    endtask

    // Full-range random operands with subadd toggling every sample.
    task automatic test_back_to_back();
        logic signed [63:0] q[$];
        logic signed [63:0] obs;
        logic signed [63:0] exp;
        int d, a, b;
        bit s;
        ce = 1'b1;
        for (int i = 0; i < 42; i++) begin
            d = rnd(-32768, 32767);
            a = rnd(-32768, 32767);
            b = rnd(-32768, 32767);
            s = i[0];
            drive(d, a, b, s);
            q.push_back(model(d, a, b, s));
            tick();
            if (q.size() == 3) begin
                exp = q.pop_front();
                obs = pout;
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL b2b[%0d]: got %0d expected %0d", i - 2, obs, exp);
                end
            end
        end
    endtask

    // ce low for 2 cycles mid-stream with changing inputs: output frozen, no loss or repeat.
    task automatic test_stall();
        logic signed [63:0] q[$];
        logic signed [63:0] obs;
        logic signed [63:0] exp;
        logic signed [63:0] last_exp = '0;
        bit have_last = 1'b0;
        int d, a, b;
        bit s;
        for (int i = 0; i < 16; i++) begin
            ce = !(i == 6 || i == 7);
            if (i < 14) begin
                d = rnd(-1000, 1000);
                a = rnd(-1000, 1000);
                b = rnd(-1000, 1000);
                s = ($urandom_range(1) == 1);
            end else begin
                d = 0; a = 0; b = 0; s = 1'b0;
            end
            drive(d, a, b, s);
            if (ce) q.push_back(model(d, a, b, s));
            tick();
            obs = pout;
            if (ce) begin
                if (q.size() == 3) begin
                    exp = q.pop_front();
                    last_exp  = exp;
                    have_last = 1'b1;
                    total++;
                    if (obs !== exp) begin
                        bad++;
                        $display("FAIL stall_seq[%0d]: got %0d expected %0d", i, obs, exp);
                    end
                end
            end else if (have_last) begin
                total++;
                if (obs !== last_exp) begin
                    bad++;
                    $display("FAIL stall_hold[%0d]: got %0d expected %0d", i, obs, last_exp);
                end
            end
        end
        ce = 1'b1;
    endtask

    // Reset with nonzero samples in flight; the first valid result follows 3 enabled clocks.
    task automatic test_reset_midstream();
        logic signed [63:0] obs;
        logic signed [63:0] exp;
        ce = 1'b1;
        drive(1000, 1, 7, 1'b0);
        repeat (3) tick();
        drive(-500, 300, -11, 1'b1);
        tick();
        #2;
        rst = 1'b0;
        #1;
        obs = pout;
        total++;
        if (obs !== 64'sd0) begin
            bad++;
            $display("FAIL midreset_immediate: got %0d expected 0", obs);
        end
        tick();
        rst = 1'b1;
        drive(-123, 45, 67, 1'b1);
        exp = model(-123, 45, 67, 1'b1);
        tick();
        drive(0, 0, 0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            obs = pout;
            total++;
            if (obs !== 64'sd0) begin
                bad++;
                $display("FAIL midreset_flushed[%0d]: got %0d expected 0", i, obs);
            end
            tick();
        end
        obs = pout;
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL midreset_first: got %0d expected %0d", obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        ce  = 1'b0;
        drive(0, 0, 0, 1'b0);
        #1;
        test_reset();
        test_directed();
        test_stream();
        test_back_to_back();
        test_stall();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
